bus_arb: RTL and testbench
==========================

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, memory data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, maximum consecutive denied cycles for a waiting master.
REQ-004 SHALL have port clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset_in  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req_in  input  1, and m0_addr_in  input  ADDR_WIDTH; m0 is the instruction-fetch master and is read-only.
REQ-007 SHALL have ports m0_gnt_out  output  1, m0_rvalid_out  output  1, and m0_rdata_out  output  DATA_WIDTH.
REQ-008 SHALL have ports m1_req_in  input  1, m1_we_in  input  1, m1_addr_in  input  ADDR_WIDTH, and m1_wdata_in  input  DATA_WIDTH; m1 is the load/store master.
REQ-009 SHALL have ports m1_gnt_out  output  1, m1_rvalid_out  output  1, and m1_rdata_out  output  DATA_WIDTH.
REQ-010 SHALL have ports s_ce_out  output  1, s_we_out  output  1, s_addr_out  output  ADDR_WIDTH, s_wdata_out  output  DATA_WIDTH, and s_rdata_in  input  DATA_WIDTH; these form the shared single-port memory, which returns read data one cycle after ce with we low.
REQ-011 SHALL have port stallreq_out  output  1  to pipe_ctrl; it is high while any requesting master is not granted.

Function
REQ-012 SHALL grant at most one master per cycle; the grant is combinational from the req inputs and arbitration state.
REQ-013 In a grant cycle, SHALL drive s_ce_out=1 and steer the granted master's addr/we/wdata to s_*; m0 grants SHALL force s_we_out=0.
REQ-014 When no grant is issued, SHALL drive s_ce_out=0 and s_we_out=0; s_addr_out/s_wdata_out are don't-care.
REQ-015 SHALL register the owner of each read grant (rd_owner, plus a valid bit).
REQ-016 In the cycle after a read grant, SHALL pulse that owner's rvalid_out and present s_rdata_in on its rdata_out.
REQ-017 m*_rdata_out SHALL be zero when the corresponding rvalid is low.
REQ-018 Writes SHALL complete in the grant cycle and SHALL produce no rvalid.
REQ-019 SHALL allow back-to-back grants every cycle; a new grant may coincide with the rvalid of the previous read.
REQ-020 Fixed-priority mode SHALL grant m1 over m0 when both request.
REQ-021 Fixed-priority mode SHALL keep a wait counter that increments each cycle m0 requests and is denied, and clears on m0 grant or when m0_req_in is low.
REQ-022 When the wait counter equals STARVE_LIMIT, SHALL grant m0 regardless of m1.
REQ-023 The wait counter SHALL saturate at STARVE_LIMIT and never wrap.
REQ-024 stallreq_out SHALL equal (m0_req_in & ~m0_gnt_out) | (m1_req_in & ~m1_gnt_out).
REQ-025 A master SHALL hold req/addr/we/wdata stable until granted; the arbiter SHALL NOT latch request payload.
REQ-026 A req deasserted before grant SHALL be treated as withdrawn, with no side effects.

Reset
REQ-027 On reset_in low, SHALL clear rd_owner valid, wait counter and rvalid outputs immediately, independent of clk_in.
REQ-028 On reset_in low, SHALL set the last-grant pointer to m0.
REQ-029 While reset_in is low, SHALL hold all gnt, s_ce_out, s_we_out and stallreq_out at 0.
REQ-030 A read granted in the cycle reset asserts SHALL produce no rvalid after reset releases.
REQ-031 The first grant after reset release SHALL be issued in the first cycle a req is seen.

Configuration
REQ-032 With macro BUS_ARB_RR_EN defined, SHALL use round-robin arbitration.
REQ-033 In round-robin mode, on contention the master not granted last SHALL win; the last-grant pointer updates on every grant.
REQ-034 In round-robin mode, the wait counter and STARVE_LIMIT SHALL be unused.
REQ-035 Without BUS_ARB_RR_EN, SHALL use fixed priority with the starvation escape (REQ-020..REQ-023).

Structure
REQ-036 Master ID constants (BUS_M0, BUS_M1) and the STARVE_LIMIT default SHALL live in shared defines.v.
REQ-037 The winner-pick logic SHALL be one sub-module, bus_arb_sel, taking req vector, pointer and starve flag and returning a one-hot grant; the top holds all registers.

Verification
REQ-038 Only m0 requests addr 0x100 for 3 cycles -> m0_gnt_out=1 on each; m0_rvalid_out on cycles 2-4 with memory data; stallreq_out=0.
REQ-039 Fixed mode, m0 and m1 (read 0x200) request continuously -> m1 is granted cycles 1-4, m0 is forced in cycle 5 (counter=4), then m1 again; stallreq_out=1 on m0-denied cycles.
REQ-040 RR mode, both requesting continuously -> grants alternate m1,m0,m1,m0 starting with m1 after reset.
REQ-041 m1 writes 0xDEADBEEF to 0x40, then m0 reads 0x40 the next cycle -> s_we_out=1 then 0; m0_rdata_out=0xDEADBEEF; m1_rvalid_out never asserts.
REQ-042 Assert reset_in low mid-cycle right after an m1 read grant -> m1_rvalid_out stays 0 and all outputs read 0 immediately.
REQ-043 m0 requests, is denied once, then drops req -> no m0 grant, wait counter returns to 0, no m0_rvalid_out.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared constants for the two-master memory arbiter.
//   BUS_M0 / BUS_M1   : master IDs used for the read-owner and last-grant state
//   BUS_STARVE_LIMIT  : default for the fixed-priority starvation escape
//   gnt_vec_t         : one-hot grant vector, bit i = master i
package bus_arb_pkg;

   localparam logic BUS_M0 = 1'b0;
   localparam logic BUS_M1 = 1'b1;

   localparam int BUS_STARVE_LIMIT = 4;

   typedef logic [1:0] gnt_vec_t;

endpackage

// File: rtl/bus_arb_sel.sv
// bus_arb_sel: combinational winner pick for bus_arb.
// Ports:
//   req      : request vector, bit 0 = m0 (fetch), bit 1 = m1 (load/store)
//   last_ptr : master granted most recently (round-robin only)
//   starve   : m0 wait counter has reached its limit (fixed priority only)
//   gnt      : one-hot grant, all zero when nothing is requested
// Build option: BUS_ARB_RR_EN selects round-robin; otherwise fixed priority
// (m1 over m0) with a starvation escape for m0.
module bus_arb_sel
   import bus_arb_pkg::*;
(
   input  logic     [1:0] req,
   input  logic           last_ptr,
   input  logic           starve,
   output gnt_vec_t       gnt
);

`ifdef BUS_ARB_RR_EN
   // Starvation cannot occur with round-robin, so the flag is ignored.
   logic unused_starve;
   assign unused_starve = starve;

   always_comb begin
      gnt = 2'b00;
      if (req == 2'b11) begin
         gnt = (last_ptr == BUS_M0) ? 2'b10 : 2'b01;
      end else begin
         gnt = req;
      end
   end
`else
   logic unused_last_ptr;
   assign unused_last_ptr = last_ptr;

   always_comb begin
      gnt = 2'b00;
      if (starve && req[0]) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end else if (req[0]) begin
         gnt = 2'b01;
      end
   end
`endif

endmodule

// File: rtl/bus_arb.sv
// bus_arb: arbitrates an instruction-fetch master (m0, read-only) and a
// load/store master (m1) onto one single-port memory whose read data
// arrives one cycle after the access.
// Ports:
//   clk_in, reset_in                  : clock, async active-low reset
//   m0_req/addr, m0_gnt/rvalid/rdata  : fetch master
//   m1_req/we/addr/wdata, m1_gnt/...  : load/store master
//   s_ce/we/addr/wdata, s_rdata_in    : shared memory port
//   stallreq_out                      : some requesting master was not granted
// Build option: define BUS_ARB_RR_EN for round-robin arbitration; the
// default build uses fixed priority (m1 first) with an m0 starvation escape.
// Grants are combinational; request payload is never latched, so a master
// must hold it until granted.
module bus_arb
   import bus_arb_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = BUS_STARVE_LIMIT
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic                  m0_req_in,
   input  logic [ADDR_WIDTH-1:0] m0_addr_in,
   output logic                  m0_gnt_out,
   output logic                  m0_rvalid_out,
   output logic [DATA_WIDTH-1:0] m0_rdata_out,
   input  logic                  m1_req_in,
   input  logic                  m1_we_in,
   input  logic [ADDR_WIDTH-1:0] m1_addr_in,
   input  logic [DATA_WIDTH-1:0] m1_wdata_in,
   output logic                  m1_gnt_out,
   output logic                  m1_rvalid_out,
   output logic [DATA_WIDTH-1:0] m1_rdata_out,
   output logic                  s_ce_out,
   output logic                  s_we_out,
   output logic [ADDR_WIDTH-1:0] s_addr_out,
   output logic [DATA_WIDTH-1:0] s_wdata_out,
   input  logic [DATA_WIDTH-1:0] s_rdata_in,
   output logic                  stallreq_out
);

   gnt_vec_t sel_gnt;
   gnt_vec_t gnt;
   logic     starve;
   logic     last_ptr;
   logic     rd_valid;
   logic     rd_owner;
   logic     rd_grant;

   bus_arb_sel u_sel (
      .req      ({m1_req_in, m0_req_in}),
      .last_ptr (last_ptr),
      .starve   (starve),
      .gnt      (sel_gnt)
   );

   // Gating with reset keeps grants, memory strobes and stall low during
   // reset and stops a read issued in that cycle from being captured.
   assign gnt        = sel_gnt & {2{reset_in}};
   assign m0_gnt_out = gnt[0];
   assign m1_gnt_out = gnt[1];

   assign s_ce_out    = |gnt;
   assign s_we_out    = gnt[1] & m1_we_in;
   assign s_addr_out  = gnt[1] ? m1_addr_in : (gnt[0] ? m0_addr_in : '0);
   assign s_wdata_out = gnt[1] ? m1_wdata_in : '0;

   assign stallreq_out = reset_in &
                         ((m0_req_in & ~gnt[0]) | (m1_req_in & ~gnt[1]));

   // m0 is read-only, so any m0 grant is a read.
   assign rd_grant = gnt[0] | (gnt[1] & ~m1_we_in);

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         rd_valid <= 1'b0;
         rd_owner <= BUS_M0;
         last_ptr <= BUS_M0;
      end else begin
         rd_valid <= rd_grant;
         if (rd_grant) begin
            rd_owner <= gnt[1] ? BUS_M1 : BUS_M0;
         end
         if (|gnt) begin
            last_ptr <= gnt[1] ? BUS_M1 : BUS_M0;
         end
      end
   end

   assign m0_rvalid_out = rd_valid & (rd_owner == BUS_M0);
   assign m1_rvalid_out = rd_valid & (rd_owner == BUS_M1);
   assign m0_rdata_out  = m0_rvalid_out ? s_rdata_in : '0;
   assign m1_rdata_out  = m1_rvalid_out ? s_rdata_in : '0;

`ifdef BUS_ARB_RR_EN
   assign starve = 1'b0;
`else
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] wait_cnt;

   assign starve = (wait_cnt == CNT_W'(STARVE_LIMIT));

   // Counts consecutive denied m0 cycles; a withdrawn request or an m0
   // grant restarts the count, and it holds at the limit instead of wrapping.
   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         wait_cnt <= '0;
      end else if (!m0_req_in || gnt[0]) begin
         wait_cnt <= '0;
      end else if (!starve) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_bus_arb.sv
module tb_bus_arb;

   logic        clk_in = 1'b0;
   logic        reset_in;
   logic        m0_req_in;
   logic [31:0] m0_addr_in;
   logic        m0_gnt_out;
   logic        m0_rvalid_out;
   logic [31:0] m0_rdata_out;
   logic        m1_req_in;
   logic        m1_we_in;
   logic [31:0] m1_addr_in;
   logic [31:0] m1_wdata_in;
   logic        m1_gnt_out;
   logic        m1_rvalid_out;
   logic [31:0] m1_rdata_out;
   logic        s_ce_out;
   logic        s_we_out;
   logic [31:0] s_addr_out;
   logic [31:0] s_wdata_out;
   logic [31:0] s_rdata_in;
   logic        stallreq_out;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:1023];

   always #5 clk_in = ~clk_in;

   bus_arb dut (
      .clk_in        (clk_in),
      .reset_in      (reset_in),
      .m0_req_in     (m0_req_in),
      .m0_addr_in    (m0_addr_in),
      .m0_gnt_out    (m0_gnt_out),
      .m0_rvalid_out (m0_rvalid_out),
      .m0_rdata_out  (m0_rdata_out),
      .m1_req_in     (m1_req_in),
      .m1_we_in      (m1_we_in),
      .m1_addr_in    (m1_addr_in),
      .m1_wdata_in   (m1_wdata_in),
      .m1_gnt_out    (m1_gnt_out),
      .m1_rvalid_out (m1_rvalid_out),
      .m1_rdata_out  (m1_rdata_out),
      .s_ce_out      (s_ce_out),
      .s_we_out      (s_we_out),
      .s_addr_out    (s_addr_out),
      .s_wdata_out   (s_wdata_out),
      .s_rdata_in    (s_rdata_in),
      .stallreq_out  (stallreq_out)
   );

   // Single-port memory model: write in the access cycle, read data next cycle.
   always @(posedge clk_in) begin
      if (s_ce_out) begin
         if (s_we_out) mem[s_addr_out[11:2]] <= s_wdata_out;
         else          s_rdata_in <= mem[s_addr_out[11:2]];
      end
   end

   task automatic set_idle();
      m0_req_in   = 1'b0;
      m0_addr_in  = 32'h0;
      m1_req_in   = 1'b0;
      m1_we_in    = 1'b0;
      m1_addr_in  = 32'h0;
      m1_wdata_in = 32'h0;
   endtask

   // Leaves the bench at a negedge with reset just released.
   task automatic do_reset();
      set_idle();
      reset_in = 1'b0;
      repeat (2) @(negedge clk_in);
      reset_in = 1'b1;
   endtask

   task automatic test_reset();
      set_idle();
      reset_in  = 1'b0;
      m0_req_in = 1'b1;
      m1_req_in = 1'b1;
      @(negedge clk_in);
      #1;
      n_tests++;
      if ({m0_gnt_out, m1_gnt_out, s_ce_out, s_we_out, stallreq_out} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: gnt0/gnt1/ce/we/stall=%b required 00000",
                  {m0_gnt_out, m1_gnt_out, s_ce_out, s_we_out, stallreq_out});
      end
      n_tests++;
      if ({m0_rvalid_out, m1_rvalid_out} !== 2'b00 || m0_rdata_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rvalid: rvalid=%b rdata0=%h required 00 / 0",
                  {m0_rvalid_out, m1_rvalid_out}, m0_rdata_out);
      end
      @(negedge clk_in);
      m1_req_in  = 1'b0;
      m0_addr_in = 32'h100;
      reset_in   = 1'b1;
      #1;
      n_tests++;
      if (m0_gnt_out !== 1'b1 || s_ce_out !== 1'b1) begin
         n_fail++;
         $display("FAIL first_grant: gnt0=%b ce=%b required 1 1", m0_gnt_out, s_ce_out);
      end
      @(negedge clk_in);
      set_idle();
   endtask

   task automatic test_m0_reads();
      do_reset();
      m0_addr_in = 32'h100;
      for (int c = 1; c <= 4; c++) begin
         m0_req_in = (c <= 3);
         #1;
         n_tests++;
         if (m0_gnt_out !== (c <= 3) || stallreq_out !== 1'b0) begin
            n_fail++;
            $display("FAIL m0_read_gnt c%0d: gnt0=%b stall=%b required %b 0",
                     c, m0_gnt_out, stallreq_out, (c <= 3));
         end
         n_tests++;
         if (m0_rvalid_out !== (c >= 2) ||
             m0_rdata_out !== ((c >= 2) ? 32'h1000_0040 : 32'h0)) begin
            n_fail++;
            $display("FAIL m0_read_data c%0d: rvalid=%b rdata=%h required %b %h",
                     c, m0_rvalid_out, m0_rdata_out, (c >= 2),
                     (c >= 2) ? 32'h1000_0040 : 32'h0);
         end
         @(negedge clk_in);
      end
      set_idle();
   endtask

`ifndef BUS_ARB_RR_EN
   task automatic test_fixed_starve();
      logic eg0;
      logic prev0;
      do_reset();
      m0_req_in  = 1'b1;
      m0_addr_in = 32'h100;
      m1_req_in  = 1'b1;
      m1_addr_in = 32'h200;
      for (int c = 1; c <= 11; c++) begin
         eg0   = (c % 5 == 0);
         prev0 = ((c - 1) % 5 == 0);
         #1;
         n_tests++;
         if (m0_gnt_out !== eg0 || m1_gnt_out !== ~eg0 || stallreq_out !== 1'b1) begin
            n_fail++;
            $display("FAIL starve_gnt c%0d: gnt0=%b gnt1=%b stall=%b required %b %b 1",
                     c, m0_gnt_out, m1_gnt_out, stallreq_out, eg0, ~eg0);
         end
         n_tests++;
         if (s_addr_out !== (eg0 ? 32'h100 : 32'h200) || s_we_out !== 1'b0) begin
            n_fail++;
            $display("FAIL starve_addr c%0d: addr=%h we=%b required %h 0",
                     c, s_addr_out, s_we_out, eg0 ? 32'h100 : 32'h200);
         end
         if (c >= 2) begin
            n_tests++;
            if (m0_rvalid_out !== prev0 || m1_rvalid_out !== ~prev0 ||
                m1_rdata_out !== (prev0 ? 32'h0 : 32'h1000_0080)) begin
               n_fail++;
               $display("FAIL starve_rvalid c%0d: rv0=%b rv1=%b rdata1=%h required %b %b",
                        c, m0_rvalid_out, m1_rvalid_out, m1_rdata_out, prev0, ~prev0);
            end
         end
         @(negedge clk_in);
      end
      set_idle();
   endtask
`else
   task automatic test_rr();
      logic eg1;
      do_reset();
      m0_req_in  = 1'b1;
      m0_addr_in = 32'h100;
      m1_req_in  = 1'b1;
      m1_addr_in = 32'h200;
      for (int c = 1; c <= 6; c++) begin
         eg1 = (c % 2 == 1);
         #1;
         n_tests++;
         if (m1_gnt_out !== eg1 || m0_gnt_out !== ~eg1 || stallreq_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_gnt c%0d: gnt0=%b gnt1=%b stall=%b required %b %b 1",
                     c, m0_gnt_out, m1_gnt_out, stallreq_out, ~eg1, eg1);
         end
         @(negedge clk_in);
      end
      set_idle();
   endtask
`endif

   task automatic test_write_then_read();
      do_reset();
      m1_req_in   = 1'b1;
      m1_we_in    = 1'b1;
      m1_addr_in  = 32'h40;
      m1_wdata_in = 32'hDEAD_BEEF;
      #1;
      n_tests++;
      if (m1_gnt_out !== 1'b1 || s_ce_out !== 1'b1 || s_we_out !== 1'b1 ||
          s_addr_out !== 32'h40 || s_wdata_out !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL wr_cycle: gnt1=%b ce=%b we=%b addr=%h wdata=%h required 1 1 1 40 deadbeef",
                  m1_gnt_out, s_ce_out, s_we_out, s_addr_out, s_wdata_out);
      end
      @(negedge clk_in);
      set_idle();
      m0_req_in  = 1'b1;
      m0_addr_in = 32'h40;
      #1;
      n_tests++;
      if (m0_gnt_out !== 1'b1 || s_we_out !== 1'b0 || m1_rvalid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_after_wr: gnt0=%b we=%b rv1=%b required 1 0 0",
                  m0_gnt_out, s_we_out, m1_rvalid_out);
      end
      @(negedge clk_in);
      set_idle();
      #1;
      n_tests++;
      if (m0_rvalid_out !== 1'b1 || m0_rdata_out !== 32'hDEAD_BEEF || m1_rvalid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_data_wr: rv0=%b rdata0=%h rv1=%b required 1 deadbeef 0",
                  m0_rvalid_out, m0_rdata_out, m1_rvalid_out);
      end
      @(negedge clk_in);
   endtask

   task automatic test_reset_mid();
      do_reset();
      m1_req_in  = 1'b1;
      m1_addr_in = 32'h200;
      #1;
      n_tests++;
      if (m1_gnt_out !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_grant: gnt1=%b required 1", m1_gnt_out);
      end
      @(posedge clk_in);
      #2;
      reset_in = 1'b0;
      #1;
      n_tests++;
      if (m1_rvalid_out !== 1'b0 || m1_rdata_out !== 32'h0 || m1_gnt_out !== 1'b0 ||
          s_ce_out !== 1'b0 || stallreq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: rv1=%b rdata1=%h gnt1=%b ce=%b stall=%b required 0 0 0 0 0",
                  m1_rvalid_out, m1_rdata_out, m1_gnt_out, s_ce_out, stallreq_out);
      end
      @(negedge clk_in);
      @(negedge clk_in);
      set_idle();
      reset_in = 1'b1;
      @(negedge clk_in);
      #1;
      n_tests++;
      if (m1_rvalid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_rvalid: rv1=%b required 0", m1_rvalid_out);
      end
      @(negedge clk_in);
   endtask

   task automatic test_withdraw();
      do_reset();
      m0_req_in  = 1'b1;
      m0_addr_in = 32'h100;
      m1_req_in  = 1'b1;
      m1_addr_in = 32'h200;
      #1;
      n_tests++;
      if (m0_gnt_out !== 1'b0 || m1_gnt_out !== 1'b1) begin
         n_fail++;
         $display("FAIL wd_denied: gnt0=%b gnt1=%b required 0 1", m0_gnt_out, m1_gnt_out);
      end
      @(negedge clk_in);
      m0_req_in = 1'b0;
      #1;
      n_tests++;
      if (m0_gnt_out !== 1'b0 || stallreq_out !== 1'b0) begin
         n_fail++;
         $display("FAIL wd_dropped: gnt0=%b stall=%b required 0 0", m0_gnt_out, stallreq_out);
      end
      @(negedge clk_in);
      set_idle();
      for (int c = 1; c <= 2; c++) begin
         #1;
         n_tests++;
         if (m0_rvalid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_rvalid c%0d: rv0=%b required 0", c, m0_rvalid_out);
         end
         @(negedge clk_in);
      end
`ifndef BUS_ARB_RR_EN
      // Counter must have restarted: m0 is forced only on the fifth cycle.
      m0_req_in  = 1'b1;
      m0_addr_in = 32'h100;
      m1_req_in  = 1'b1;
      m1_addr_in = 32'h200;
      for (int c = 1; c <= 5; c++) begin
         #1;
         n_tests++;
         if (m0_gnt_out !== (c == 5)) begin
            n_fail++;
            $display("FAIL wd_cnt_clear c%0d: gnt0=%b required %b", c, m0_gnt_out, (c == 5));
         end
         @(negedge clk_in);
      end
      set_idle();
`endif
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
      s_rdata_in = 32'h0;
      set_idle();
      reset_in = 1'b0;
      test_reset();
      test_m0_reads();
`ifndef BUS_ARB_RR_EN
      test_fixed_starve();
`else
      test_rr();
`endif
      test_write_then_read();
      test_reset_mid();
      test_withdraw();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
